// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_t;

  // RV32I funct3 encodings for loads and stores
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  // Loads accept 0,1,2,4,5; stores accept 0,1,2.
  function automatic logic f3_supported(input logic we, input logic [2:0] f3);
    if (we) return (f3 <= F3_SW);
    return (f3 != 3'd3) && (f3 <= F3_LHU);
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes never misalign.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return (lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Lane extract/extend for loads and lane merge for sub-word stores.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Halfword lane only looks at addr[1], so an odd halfword address folds down.
  assign byte_lane = rword_i[{addr_lo_i, 3'b000} +: 8];
  assign half_lane = rword_i[{addr_lo_i[1], 4'b0000} +: 16];

  // Load result: pick the lane, then sign- or zero-extend by funct3
  always_comb begin
    load_data_o = rword_i;
    case (funct3_i)
      F3_LB:   load_data_o = {{24{byte_lane[7]}}, byte_lane};
      F3_LBU:  load_data_o = {24'h0, byte_lane};
      F3_LH:   load_data_o = {{16{half_lane[15]}}, half_lane};
      F3_LHU:  load_data_o = {16'h0, half_lane};
      default: load_data_o = rword_i;
    endcase
  end

  // Store word: overlay the low bits of wdata onto the word just read
  always_comb begin
    store_word_o = rword_i;
    case (funct3_i)
      F3_SB:   store_word_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_SH:   store_word_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: store_word_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store in flight, RMW for sub-word stores.
// Latency: bad/unsupported 1, SW 2, loads 3, SB/SH 4 cycles to resp_valid.
// Backpressure: req_ready only in IDLE; optional LSU_MISALIGN_CHECK_EN rejects misaligned H/W.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_w_enable,
  input  logic [31:0] mem_data_out
);

  lsu_state_t  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;   // SW data, or the merged word for SB/SH
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic        req_mis;

  logic [31:0] load_data;
  logic [31:0] store_word;

  lsu_align u_align (
    .funct3_i     (f3_q),
    .addr_lo_i    (addr_q[1:0]),
    .rword_i      (mem_data_out),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

`ifdef LSU_MISALIGN_CHECK_EN
  assign req_mis = f3_supported(req_we, req_funct3) && f3_misaligned(req_funct3, req_addr[1:0]);
`else
  assign req_mis = 1'b0;
`endif

  assign resp_rdata      = rdata_q;
  assign resp_misaligned = mis_q;

  // State and request/response registers; reset abandons any request in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  // Next state, captured data and memory/handshake outputs
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    mis_d        = mis_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_address  = 32'h0;
    mem_data_in  = 32'h0;
    mem_w_enable = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = 32'h0;
          mis_d   = req_mis;
          if (req_mis || !f3_supported(req_we, req_funct3)) state_d = ST_RESP;
          else if (req_we && (req_funct3 == F3_SW))         state_d = ST_WRITE;
          else                                              state_d = ST_READ;
        end
      end
      ST_READ: begin
        mem_address = {addr_q[31:2], 2'b00};
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (we_q) begin
          wdata_d = store_word;
          state_d = ST_WRITE;
        end else begin
          rdata_d = load_data;
          state_d = ST_RESP;
        end
      end
      ST_WRITE: begin
        mem_address  = {addr_q[31:2], 2'b00};
        mem_data_in  = wdata_q;
        mem_w_enable = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural word memory.
// Latency: n/a.
// Backpressure: requests driven only when req_ready is expected high.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_misaligned;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_w_enable;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    int          exp_lat;
    logic        exp_wr;
    logic [31:0] exp_wdat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
  } resp_t;

  vec_t  vecs[$];
  resp_t sb_q[$];
  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .mem_address     (mem_address),
    .mem_data_in     (mem_data_in),
    .mem_w_enable    (mem_w_enable),
    .mem_data_out    (mem_data_out)
  );

  // Word memory: synchronous read, no reset
  always @(posedge clk) begin
    if (mem_w_enable) mem[mem_address[9:2]] <= mem_data_in;
    mem_data_out <= mem[mem_address[9:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every response pops the oldest expectation
  always @(negedge clk) begin
    if (reset_n === 1'b1 && resp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        resp_t e;
        e = sb_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_misaligned", {31'h0, resp_misaligned}, {31'h0, e.mis});
      end
    end
  end

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] erd, input logic emis,
                              input int elat, input logic ewr, input logic [31:0] ewd);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = erd; v.exp_mis = emis; v.exp_lat = elat; v.exp_wr = ewr; v.exp_wdat = ewd;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int cyc, lat, nwr, wcyc, rdy_bad;
    logic [31:0] waddr, wdat;
    resp_t e;
    @(negedge clk);
    chk("ready_before_req", {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    e.rdata = v.exp_rdata; e.mis = v.exp_mis;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = $urandom_range(1); req_funct3 = 3'($urandom_range(7));
    req_addr = $urandom; req_wdata = $urandom;
    cyc = 1; lat = 0; nwr = 0; wcyc = 0; rdy_bad = 0; waddr = 0; wdat = 0;
    while (lat == 0 && cyc < 12) begin
      if (req_ready) rdy_bad++;
      if (mem_w_enable) begin nwr++; wcyc = cyc; waddr = mem_address; wdat = mem_data_in; end
      if (resp_valid) lat = cyc;
      else begin @(negedge clk); cyc++; end
    end
    chk("latency", lat, v.exp_lat);
    chk("ready_low_in_flight", rdy_bad, 0);
    chk("write_count", nwr, v.exp_wr ? 1 : 0);
    if (v.exp_wr) begin
      chk("write_cycle", wcyc, v.exp_lat - 1);
      chk("write_addr", waddr, {v.addr[31:2], 2'b00});
      chk("write_data", wdat, v.exp_wdat);
    end
  endtask

  initial begin
    logic [31:0] saved;
    int cyc, acc2, nwr;
    for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    mem[8'h40] <= 32'h8899AABB;
    mem[8'hC0] <= 32'h11223344;
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;

    // Loads, stores and unsupported encodings
    vecs.push_back(mk(0, 3'd0, 32'h101, 32'h0, 32'hFFFFFFAA, 0, 3, 0, 32'h0));
    vecs.push_back(mk(0, 3'd4, 32'h101, 32'h0, 32'h000000AA, 0, 3, 0, 32'h0));
    vecs.push_back(mk(0, 3'd1, 32'h102, 32'h0, 32'hFFFF8899, 0, 3, 0, 32'h0));
    vecs.push_back(mk(0, 3'd5, 32'h102, 32'h0, 32'h00008899, 0, 3, 0, 32'h0));
    vecs.push_back(mk(0, 3'd0, 32'h103, 32'h0, 32'hFFFFFF88, 0, 3, 0, 32'h0));
    vecs.push_back(mk(0, 3'd4, 32'h100, 32'h0, 32'h000000BB, 0, 3, 0, 32'h0));
    vecs.push_back(mk(0, 3'd2, 32'h100, 32'h0, 32'h8899AABB, 0, 3, 0, 32'h0));
    vecs.push_back(mk(1, 3'd2, 32'h200, 32'hDEADBEEF, 32'h0, 0, 2, 1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 3'd2, 32'h200, 32'h0, 32'hDEADBEEF, 0, 3, 0, 32'h0));
    vecs.push_back(mk(1, 3'd0, 32'h302, 32'h000000AB, 32'h0, 0, 4, 1, 32'h11AB3344));
    vecs.push_back(mk(1, 3'd1, 32'h300, 32'h1234CDEF, 32'h0, 0, 4, 1, 32'h11ABCDEF));
    vecs.push_back(mk(0, 3'd2, 32'h300, 32'h0, 32'h11ABCDEF, 0, 3, 0, 32'h0));
    vecs.push_back(mk(1, 3'd0, 32'h303, 32'hFFFFFF77, 32'h0, 0, 4, 1, 32'h77ABCDEF));
    vecs.push_back(mk(0, 3'd3, 32'h100, 32'h0, 32'h0, 0, 1, 0, 32'h0));
    vecs.push_back(mk(1, 3'd4, 32'h100, 32'h12345678, 32'h0, 0, 1, 0, 32'h0));
    vecs.push_back(mk(0, 3'd7, 32'h100, 32'h0, 32'h0, 0, 1, 0, 32'h0));
`ifdef LSU_MISALIGN_CHECK_EN
    vecs.push_back(mk(0, 3'd2, 32'h203, 32'h0, 32'h0, 1, 1, 0, 32'h0));
    vecs.push_back(mk(0, 3'd1, 32'h101, 32'h0, 32'h0, 1, 1, 0, 32'h0));
    vecs.push_back(mk(1, 3'd1, 32'h301, 32'h5566, 32'h0, 1, 1, 0, 32'h0));
    vecs.push_back(mk(1, 3'd2, 32'h302, 32'h5566, 32'h0, 1, 1, 0, 32'h0));
`else
    vecs.push_back(mk(0, 3'd2, 32'h203, 32'h0, 32'hDEADBEEF, 0, 3, 0, 32'h0));
    vecs.push_back(mk(0, 3'd1, 32'h101, 32'h0, 32'hFFFFAABB, 0, 3, 0, 32'h0));
    vecs.push_back(mk(1, 3'd1, 32'h301, 32'h5566, 32'h0, 0, 4, 1, 32'h77AB5566));
    vecs.push_back(mk(1, 3'd2, 32'h302, 32'hCAFEF00D, 32'h0, 0, 2, 1, 32'hCAFEF00D));
`endif

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_mis", {31'h0, resp_misaligned}, 32'd0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_data_in", mem_data_in, 32'h0);
    chk("rst_mem_w_enable", {31'h0, mem_w_enable}, 32'd0);
    reset_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during WAIT of an SB: abandoned, no response, no write
    @(negedge clk);
    saved = mem[8'hC0];
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h301; req_wdata = 32'h55;
    @(posedge clk);             // accept
    @(negedge clk); req_valid = 1'b0;   // cycle 1: READ
    @(negedge clk);             // cycle 2: WAIT
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {31'h0, req_ready}, 32'd1);
    chk("midrst_resp_valid", {31'h0, resp_valid}, 32'd0);
    chk("midrst_w_enable", {31'h0, mem_w_enable}, 32'd0);
    reset_n = 1'b1;
    nwr = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_w_enable) nwr++;
    end
    chk("midrst_no_write", nwr, 0);
    chk("midrst_mem_unchanged", mem[8'hC0], saved);

    // Back-to-back loads with req_valid held high
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h100;
    sb_q.push_back('{rdata: 32'h8899AABB, mis: 1'b0});
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h200;
    sb_q.push_back('{rdata: mem[8'h80], mis: 1'b0});
    cyc = 1; acc2 = 0; nwr = 0;
    while (acc2 == 0 && cyc < 12) begin
      if (cyc <= 3 && req_ready) nwr++;
      if (req_ready) acc2 = cyc;
      else begin @(negedge clk); cyc++; end
    end
    chk("b2b_ready_low_first", nwr, 0);
    chk("b2b_second_accept_cycle", acc2, 4);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_ready_low_second", {31'h0, req_ready}, 32'd0);
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
